// File: rtl/perspective_params_ctrl_if.sv
// perspective_params_ctrl_if
// Bus between the keystone coefficient sequencer and its neighbours:
// corner detector (frame_start, corners_*), coefficient datapath
// (corners_out / coef_in) and pixel-mapping logic (coef_out, params_*).
// Packing of a quad:  {x1[9:0],y1[8:0],x2,y2,x3,y3,x4,y4}   (76 bits)
// Packing of coefs:   {o1[67:0],o2[68:0],o3[78:0],o4[67:0],o5[68:0],
//                      o6[78:0],o7[58:0],o8[59:0],o9[70:0]} (622 bits)
// The slave modport is the sequencer itself; master is the environment.
interface perspective_params_ctrl_if;

  logic         frame_start;
  logic         corners_valid;
  logic [75:0]  corners_in;
  logic [75:0]  corners_out;
  logic [621:0] coef_in;
  logic [621:0] coef_out;
  logic         params_valid;
  logic         params_update;
  logic         busy;
  logic [7:0]   reject_cnt;

  modport slave (
    input  frame_start,
    input  corners_valid,
    input  corners_in,
    input  coef_in,
    output corners_out,
    output coef_out,
    output params_valid,
    output params_update,
    output busy,
    output reject_cnt
  );

  modport master (
    output frame_start,
    output corners_valid,
    output corners_in,
    output coef_in,
    input  corners_out,
    input  coef_out,
    input  params_valid,
    input  params_update,
    input  busy,
    input  reject_cnt
  );

endinterface

// File: rtl/perspective_params_ctrl.sv
// perspective_params_ctrl
// Sequencer for the keystone perspective coefficient datapath.
//  - IDLE: qualifies corner quads until the same quad has been reported
//          STABLE_FRAMES times in a row, then launches the datapath.
//  - RUN : holds corners_out and waits PIPE_LATENCY cycles, then captures
//          coef_in into a shadow bank.
//  - HOLD: waits for frame_start and publishes the shadow bank on coef_out,
//          so the pixel-mapping logic never sees a mid-frame change.
// Optional build macro: PERSPECTIVE_PARAMS_CTRL_DEGEN_REJECT_EN
//   When defined, quads with two coincident corners are rejected in IDLE
//   and counted in reject_cnt (saturating). When undefined, reject_cnt is
//   tied to zero and every quad is accepted.
// Reset is synchronous, active-low, on reset_n; it abandons any in-flight
// computation and clears the shadow bank.
module perspective_params_ctrl #(
  parameter int PIPE_LATENCY  = 8,
  parameter int STABLE_FRAMES = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  perspective_params_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [7:0] LAT_LOAD   = 8'(PIPE_LATENCY);
  localparam logic [3:0] STABLE_THR = 4'(STABLE_FRAMES);
  localparam logic [3:0] STABLE_MAX = 4'd15;

`ifdef PERSPECTIVE_PARAMS_CTRL_DEGEN_REJECT_EN
  // True when any two of the four corners share the same (x,y) pair.
  function automatic logic quad_degenerate(input logic [75:0] q);
    logic [18:0] c1;
    logic [18:0] c2;
    logic [18:0] c3;
    logic [18:0] c4;
    c1 = q[75:57];
    c2 = q[56:38];
    c3 = q[37:19];
    c4 = q[18:0];
    return (c1 == c2) || (c1 == c3) || (c1 == c4) ||
           (c2 == c3) || (c2 == c4) || (c3 == c4);
  endfunction
`endif

  // State and datapath registers
  logic [1:0]   state_r;
  logic [75:0]  cand_r;
  logic [3:0]   stable_cnt_r;
  logic [75:0]  active_r;
  logic [75:0]  corners_out_r;
  logic [7:0]   lat_cnt_r;
  logic [621:0] shadow_r;
  logic [621:0] coef_out_r;
  logic         params_valid_r;
  logic         params_update_r;
  logic         busy_r;

  // Next-state values
  logic [1:0]   state_s;
  logic [75:0]  cand_s;
  logic [3:0]   stable_cnt_s;
  logic [75:0]  active_s;
  logic [75:0]  corners_out_s;
  logic [7:0]   lat_cnt_s;
  logic [621:0] shadow_s;
  logic [621:0] coef_out_s;
  logic         params_valid_s;
  logic         params_update_s;
  logic         quad_ok_s;

`ifdef PERSPECTIVE_PARAMS_CTRL_DEGEN_REJECT_EN
  logic [7:0]   reject_cnt_r;
  logic [7:0]   reject_cnt_s;
  assign quad_ok_s = !quad_degenerate(bus.corners_in);
`else
  assign quad_ok_s = 1'b1;
`endif

  // Next-state logic for the IDLE/RUN/HOLD sequencer and its registers.
  always_comb begin
    state_s         = state_r;
    cand_s          = cand_r;
    stable_cnt_s    = stable_cnt_r;
    active_s        = active_r;
    corners_out_s   = corners_out_r;
    lat_cnt_s       = lat_cnt_r;
    shadow_s        = shadow_r;
    coef_out_s      = coef_out_r;
    params_valid_s  = params_valid_r;
    params_update_s = 1'b0;
`ifdef PERSPECTIVE_PARAMS_CTRL_DEGEN_REJECT_EN
    reject_cnt_s    = reject_cnt_r;
`endif

    case (state_r)
      ST_IDLE: begin
        // Qualification: same quad counts up, a new quad restarts at 1.
        if (bus.corners_valid) begin
          if (!quad_ok_s) begin
            stable_cnt_s = 4'd0;
`ifdef PERSPECTIVE_PARAMS_CTRL_DEGEN_REJECT_EN
            if (reject_cnt_r != 8'hFF) begin
              reject_cnt_s = reject_cnt_r + 8'd1;
            end else begin
              reject_cnt_s = reject_cnt_r;
            end
`endif
          end else if (bus.corners_in == cand_r) begin
            if (stable_cnt_r != STABLE_MAX) begin
              stable_cnt_s = stable_cnt_r + 4'd1;
            end else begin
              stable_cnt_s = stable_cnt_r;
            end
          end else begin
            cand_s       = bus.corners_in;
            stable_cnt_s = 4'd1;
          end
        end else begin
          stable_cnt_s = stable_cnt_r;
        end

        // Launch decision uses the freshly updated candidate/count so a
        // quad that becomes stable launches on that very edge. A quad that
        // matches what is already published never relaunches.
        if ((stable_cnt_s >= STABLE_THR) &&
            ((cand_s != active_r) || !params_valid_r)) begin
          corners_out_s = cand_s;
          lat_cnt_s     = LAT_LOAD;
          state_s       = ST_RUN;
        end else begin
          state_s       = ST_IDLE;
        end
      end

      ST_RUN: begin
        // corners_out is frozen; coef_in is valid on the edge where the
        // counter reaches 1, i.e. PIPE_LATENCY cycles after launch.
        if (lat_cnt_r == 8'd1) begin
          shadow_s  = bus.coef_in;
          lat_cnt_s = 8'd0;
          state_s   = ST_HOLD;
        end else begin
          lat_cnt_s = lat_cnt_r - 8'd1;
          state_s   = ST_RUN;
        end
      end

      ST_HOLD: begin
        // Publish only at a frame boundary. A frame_start coinciding with
        // the RUN->HOLD edge was seen in RUN and therefore does not count.
        if (bus.frame_start) begin
          coef_out_s      = shadow_r;
          params_valid_s  = 1'b1;
          params_update_s = 1'b1;
          active_s        = corners_out_r;
          stable_cnt_s    = 4'd0;
          state_s         = ST_IDLE;
        end else begin
          state_s         = ST_HOLD;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        lat_cnt_s = 8'd0;
      end
    endcase
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r         <= ST_IDLE;
      cand_r          <= 76'd0;
      stable_cnt_r    <= 4'd0;
      active_r        <= 76'd0;
      corners_out_r   <= 76'd0;
      lat_cnt_r       <= 8'd0;
      shadow_r        <= 622'd0;
      coef_out_r      <= 622'd0;
      params_valid_r  <= 1'b0;
      params_update_r <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      state_r         <= state_s;
      cand_r          <= cand_s;
      stable_cnt_r    <= stable_cnt_s;
      active_r        <= active_s;
      corners_out_r   <= corners_out_s;
      lat_cnt_r       <= lat_cnt_s;
      shadow_r        <= shadow_s;
      coef_out_r      <= coef_out_s;
      params_valid_r  <= params_valid_s;
      params_update_r <= params_update_s;
      busy_r          <= (state_s != ST_IDLE);
    end
  end

`ifdef PERSPECTIVE_PARAMS_CTRL_DEGEN_REJECT_EN
  // Saturating count of rejected degenerate quads.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      reject_cnt_r <= 8'd0;
    end else begin
      reject_cnt_r <= reject_cnt_s;
    end
  end

  assign bus.reject_cnt = reject_cnt_r;
`else
  assign bus.reject_cnt = 8'd0;
`endif

  assign bus.corners_out   = corners_out_r;
  assign bus.coef_out      = coef_out_r;
  assign bus.params_valid  = params_valid_r;
  assign bus.params_update = params_update_r;
  assign bus.busy          = busy_r;

endmodule

// File: tb/tb_perspective_params_ctrl.sv
// Directed testbench for perspective_params_ctrl (PIPE_LATENCY=8,
// STABLE_FRAMES=2). Expected values are hand-derived constants.
module tb_perspective_params_ctrl;

  logic clock;
  logic reset_n;

  perspective_params_ctrl_if bus ();

  perspective_params_ctrl #(
    .PIPE_LATENCY  (8),
    .STABLE_FRAMES (2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [75:0] q_a;   // Q
  logic [75:0] q_x;   // Q with x1 = 383
  logic [75:0] q_d;   // corner 3 == corner 1

  // Distinct, recognisable coefficient word per index k.
  function automatic logic [621:0] mk_coef(input logic [7:0] k);
    logic [631:0] t;
    t = {79{k}};
    return t[621:0];
  endfunction

  task automatic check(input string tag, input logic [621:0] obs, input logic [621:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and stop 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One corners_valid pulse carrying quad q.
  task automatic report(input logic [75:0] q);
    bus.corners_valid = 1'b1;
    bus.corners_in    = q;
    tick();
    bus.corners_valid = 1'b0;
  endtask

  // One frame_start pulse.
  task automatic frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  initial begin
    q_a = {10'd382, 9'd380, 10'd163, 9'd401, 10'd57,  9'd335, 10'd296, 9'd127};
    q_x = {10'd383, 9'd380, 10'd163, 9'd401, 10'd57,  9'd335, 10'd296, 9'd127};
    q_d = {10'd382, 9'd380, 10'd163, 9'd401, 10'd382, 9'd380, 10'd296, 9'd127};

    reset_n           = 1'b0;
    bus.frame_start   = 1'b0;
    bus.corners_valid = 1'b0;
    bus.corners_in    = 76'd0;
    bus.coef_in       = 622'd0;
    #2;
    tick();
    tick();
    check("rst_busy",    622'(bus.busy),          622'd0);
    check("rst_cout",    622'(bus.corners_out),   622'd0);
    check("rst_coef",    bus.coef_out,            622'd0);
    check("rst_pvalid",  622'(bus.params_valid),  622'd0);
    check("rst_pupd",    622'(bus.params_update), 622'd0);
    check("rst_reject",  622'(bus.reject_cnt),    622'd0);
    reset_n = 1'b1;
    tick();

    // Stability gate: Q, Qx, Q -> counts 1,1,1, no launch; second Q launches.
    report(q_a);
    check("gate_busy1", 622'(bus.busy), 622'd0);
    report(q_x);
    check("gate_busy2", 622'(bus.busy), 622'd0);
    report(q_a);
    check("gate_busy3", 622'(bus.busy), 622'd0);
    report(q_a);
    check("gate_launch_busy", 622'(bus.busy),        622'd1);
    check("gate_launch_cout", 622'(bus.corners_out), 622'(q_a));

    // RUN: coef_in changes every cycle; only the 8th value may be captured.
    for (int i = 1; i <= 8; i++) begin
      bus.coef_in = mk_coef(8'(i));
      tick();
    end
    bus.coef_in = mk_coef(8'd99);
    check("hold_busy",   622'(bus.busy),         622'd1);
    check("hold_coef0",  bus.coef_out,           622'd0);
    check("hold_pvalid", 622'(bus.params_valid), 622'd0);
    tick();
    tick();
    check("hold_wait_coef0", bus.coef_out,       622'd0);
    frame();
    check("pub1_pupd",   622'(bus.params_update), 622'd1);
    check("pub1_pvalid", 622'(bus.params_valid),  622'd1);
    check("pub1_coef",   bus.coef_out,            mk_coef(8'd8));
    check("pub1_busy",   622'(bus.busy),          622'd0);
    tick();
    check("pub1_pupd_end", 622'(bus.params_update), 622'd0);

    // Unchanged quad never relaunches.
    for (int i = 0; i < 4; i++) begin
      report(q_a);
      check("norelaunch_busy", 622'(bus.busy),          622'd0);
      check("norelaunch_pupd", 622'(bus.params_update), 622'd0);
    end
    check("norelaunch_coef", bus.coef_out, mk_coef(8'd8));

    // New quad Qx launches; Q reported during RUN is ignored;
    // frame_start on the expiry edge does not publish.
    report(q_x);
    check("qx_busy_first", 622'(bus.busy), 622'd0);
    report(q_x);
    check("qx_launch_cout", 622'(bus.corners_out), 622'(q_x));
    for (int i = 1; i <= 8; i++) begin
      bus.coef_in = mk_coef(8'(16 + i));
      if (i == 3) begin
        bus.corners_valid = 1'b1;
        bus.corners_in    = q_a;
      end
      if (i == 8) begin
        bus.frame_start = 1'b1;
      end
      tick();
      bus.corners_valid = 1'b0;
      bus.frame_start   = 1'b0;
    end
    bus.coef_in = mk_coef(8'd99);
    check("run_cout_held",  622'(bus.corners_out),   622'(q_x));
    check("coinc_pupd",     622'(bus.params_update), 622'd0);
    check("coinc_coef",     bus.coef_out,            mk_coef(8'd8));
    check("coinc_busy",     622'(bus.busy),          622'd1);
    tick();
    frame();
    check("pub2_pupd", 622'(bus.params_update), 622'd1);
    check("pub2_coef", bus.coef_out,            mk_coef(8'd24));
    // Candidate is still Qx, so one Q report only restarts the count.
    report(q_a);
    check("ignored_in_run_busy", 622'(bus.busy), 622'd0);
    report(q_a);
    check("relaunch_q_busy", 622'(bus.busy), 622'd1);

    // Mid-operation reset at RUN count 4.
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mrst_busy",   622'(bus.busy),         622'd0);
    check("mrst_cout",   622'(bus.corners_out),  622'd0);
    check("mrst_coef",   bus.coef_out,           622'd0);
    check("mrst_pvalid", 622'(bus.params_valid), 622'd0);
    report(q_a);
    check("mrst_busy1", 622'(bus.busy), 622'd0);
    report(q_a);
    check("mrst_launch", 622'(bus.corners_out), 622'(q_a));
    for (int i = 1; i <= 8; i++) begin
      bus.coef_in = mk_coef(8'(40 + i));
      tick();
    end
    bus.coef_in = mk_coef(8'd99);
    frame();
    check("mrst_pub_coef", bus.coef_out, mk_coef(8'd48));

    // Degenerate quad handling.
    report(q_d);
    report(q_d);
`ifdef PERSPECTIVE_PARAMS_CTRL_DEGEN_REJECT_EN
    check("degen_busy2", 622'(bus.busy), 622'd0);
    report(q_d);
    check("degen_busy3",  622'(bus.busy),       622'd0);
    check("degen_reject", 622'(bus.reject_cnt), 622'd3);
`else
    check("degen_launch", 622'(bus.busy),        622'd1);
    check("degen_cout",   622'(bus.corners_out), 622'(q_d));
    report(q_d);
    check("degen_reject", 622'(bus.reject_cnt),  622'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/perspective_params_ctrl.md
Name: perspective_params_ctrl

Overview:
- Sequences the perspective_params coefficient datapath for keystone correction.
- Qualifies corner quads from the corner detector until they are stable over STABLE_FRAMES reports.
- Launches the datapath with a held quad, waits its fixed pipeline latency, and captures the 9 coefficients into a shadow bank.
- Publishes the shadow bank to the pixel-mapping logic only at a frame boundary, so coefficients never change mid-frame.

Parameters:
- PIPE_LATENCY, 8: cycles from corners_out change to valid coef_in; legal range 1..255.
- STABLE_FRAMES, 2: consecutive identical corner reports required before launch; legal range 1..15.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- corners_valid  in  1  one-cycle pulse; corners_in valid this cycle
- corners_in  in  76  {x1[9:0],y1[8:0],x2,y2,x3,y3,x4,y4}, unsigned
- corners_out  out  76  held quad driven to the datapath x1..y4, same packing
- coef_in  in  622  datapath outputs {o1[67:0],o2[68:0],o3[78:0],o4[67:0],o5[68:0],o6[78:0],o7[58:0],o8[59:0],o9[70:0]}, signed fields
- coef_out  out  622  published coefficients, same packing
- params_valid  out  1  high once any coefficient set has been published
- params_update  out  1  one-cycle pulse on the publish cycle
- busy  out  1  high whenever state is not IDLE
- reject_cnt  out  8  rejected degenerate quads; optional feature only

Behaviour:
- Clock and reset: one clock, clock; reset_n is synchronous and active-low, sampled on the posedge of clock.
- Reset values: every output is 0, state IDLE, candidate 0, stable_cnt 0, active quad 0, shadow 0.
- Reset mid-operation: an in-flight computation is abandoned and the shadow bank is discarded.

States are IDLE, RUN and HOLD.

IDLE:
- On corners_valid with corners_in equal to the candidate: stable_cnt increments, saturating at 15.
- On corners_valid with corners_in different from the candidate: candidate <= corners_in, stable_cnt <= 1.
- Launch condition, evaluated on the updated values: stable_cnt >= STABLE_FRAMES, and either candidate differs from the active quad or params_valid = 0.
- On launch: corners_out <= candidate, latency counter <= PIPE_LATENCY, state goes to RUN, all on the same edge.
- With STABLE_FRAMES = 1, launch happens on the first corners_valid edge.

RUN:
- corners_out is held constant and the counter decrements each cycle.
- On the edge where the counter equals 1, shadow <= coef_in and state goes to HOLD.
- coef_in is therefore sampled exactly PIPE_LATENCY cycles after corners_out changed.

HOLD:
- On frame_start: coef_out <= shadow, params_valid <= 1, params_update <= 1 for one cycle, active quad <= corners_out, stable_cnt <= 0, state goes to IDLE.

Boundary rules:
- corners_valid in RUN or HOLD is ignored: candidate and stable_cnt are unchanged and no queueing occurs.
- frame_start in IDLE or RUN has no effect.
- frame_start on the same edge as the RUN to HOLD transition does not publish; publish waits for the next frame_start.
- An unchanged quad never relaunches once published, regardless of how many identical reports follow.
- coef_out changes only on a params_update cycle.
- busy = (state != IDLE), registered with the state.

Widths and arithmetic:
- Quad compare is a full 76-bit equality.
- No arithmetic on coefficients; fields pass through bit-exact.

Optional Feature:
- Macro: PERSPECTIVE_PARAMS_CTRL_DEGEN_REJECT_EN.
- When defined:
  - In IDLE, a corners_valid whose quad has any two corners with identical (x,y) is rejected.
  - On rejection: candidate is unchanged, stable_cnt <= 0, and reject_cnt increments, saturating at 255.
  - reject_cnt resets to 0.
- When undefined: reject_cnt is tied to 0 and all quads are accepted.

Test Plan (PIPE_LATENCY=8, STABLE_FRAMES=2, Q = x/y 382/380, 163/401, 57/335, 296/127):
- Quad qualification: Q reported on two corners_valid pulses -> corners_out = Q on the second pulse's edge, busy=1. Model coef_in on exactly the 8th cycle after -> shadow equals it; coef_out remains 0 until frame_start. Then params_update is one pulse, params_valid=1, and coef_out matches bit-exact.
- Stability gate: Q, then Q with x1=383, then Q -> no launch (stable_cnt 1, 1, 1). A second Q -> launch.
- No relaunch of unchanged quad: after publishing Q, four more Q reports -> busy stays 0, coef_out unchanged, no params_update.
- Frame-boundary timing: corners_valid during RUN with a new quad Q' -> ignored; corners_out stays Q. frame_start coincident with the counter-expiry edge -> no publish; the next frame_start publishes.
- Mid-operation reset: reset_n=0 for 1 cycle at RUN count 4 -> all outputs 0, state IDLE. Q reported twice again -> fresh launch with full 8-cycle latency.
- Degenerate rejection (PERSPECTIVE_PARAMS_CTRL_DEGEN_REJECT_EN): quad with corner 3 = corner 1 = (382,380), reported three times -> reject_cnt=3, no launch. Without the macro -> launch after the second report, reject_cnt=0.
